// File: rtl/uart_boot_loader.sv
`timescale 1ns/1ps
// UART boot loader: receives A5, a 16-bit word count and the payload, writes words into
// instruction memory and releases the core. Define BOOT_CHECKSUM_EN to enable the trailing XOR checksum byte.
module uart_boot_loader #(
    parameter int MAX_WORDS      = 256,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        cpu_reset,
    output logic        boot_done,
    output logic        boot_error,
    output logic [2:0]  fsm_state
);

    // Handshakes: rx_data is consumed only in a cycle where rx_ready is high (one byte per pulse);
    // tx_start is a one-cycle request issued only while tx_busy is low, with tx_data stable from queueing until then.

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_CSUM   = 3'd4,
        S_DONE   = 3'd5,
        S_ERROR  = 3'd6
    } state_t;

    localparam logic [16:0] MAX_W    = 17'(MAX_WORDS);
    localparam logic [31:0] TO_LIMIT = TIMEOUT_CYCLES;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;
    localparam logic [7:0] ACK_BYTE  = 8'h06;
    localparam logic [7:0] NAK_BYTE  = 8'h15;

    state_t      state, state_nx;
    logic [7:0]  len_lo;
    logic [15:0] word_cnt;
    logic [15:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [23:0] word_sr;
    logic [31:0] to_cnt;
    logic        tx_pending;
    logic        word_wr;
    logic        active;
    logic        timeout;
    logic [15:0] n_len;
    logic        len_bad;
    logic        last_word;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    assign n_len     = {rx_data, len_lo};
    assign len_bad   = (n_len == 16'd0) || ({1'b0, n_len} > MAX_W);
    assign last_word = (word_idx == word_cnt - 16'd1);
    assign active    = (state == S_LEN_LO) || (state == S_LEN_HI) ||
                       (state == S_DATA)   || (state == S_CSUM);
    assign timeout   = active && (to_cnt == TO_LIMIT);

    assign cpu_reset = (state != S_DONE);
    assign boot_done = (state == S_DONE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // A byte arriving in the same cycle as the timeout always takes priority.
    always_comb begin
        state_nx = state;
        word_wr  = 1'b0;
        case (state)
            S_IDLE: begin
                if (rx_ready && rx_data == SYNC_BYTE) state_nx = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (rx_ready)     state_nx = S_LEN_HI;
                else if (timeout) state_nx = S_ERROR;
            end
            S_LEN_HI: begin
                if (rx_ready)     state_nx = len_bad ? S_ERROR : S_DATA;
                else if (timeout) state_nx = S_ERROR;
            end
            S_DATA: begin
                if (rx_ready) begin
                    if (byte_cnt == 2'd3) begin
                        word_wr = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                        if (last_word) state_nx = S_CSUM;
`else
                        if (last_word) state_nx = S_DONE;
`endif
                    end
                end else if (timeout) begin
                    state_nx = S_ERROR;
                end
            end
`ifdef BOOT_CHECKSUM_EN
            S_CSUM: begin
                if (rx_ready)     state_nx = (rx_data == csum) ? S_DONE : S_ERROR;
                else if (timeout) state_nx = S_ERROR;
            end
`endif
            S_DONE:  state_nx = S_DONE;
            S_ERROR: state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo     <= 8'd0;
            word_cnt   <= 16'd0;
            word_idx   <= 16'd0;
            byte_cnt   <= 2'd0;
            word_sr    <= 24'd0;
            to_cnt     <= 32'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
`ifdef BOOT_CHECKSUM_EN
            csum       <= 8'd0;
`endif
        end else begin
            imem_we <= word_wr;
            if (!active || rx_ready) to_cnt <= 32'd0;
            else                     to_cnt <= to_cnt + 32'd1;

            if (state == S_IDLE) begin
                word_idx <= 16'd0;
                byte_cnt <= 2'd0;
`ifdef BOOT_CHECKSUM_EN
                csum     <= 8'd0;
`endif
            end
            if (state == S_LEN_LO && rx_ready) len_lo   <= rx_data;
            if (state == S_LEN_HI && rx_ready) word_cnt <= n_len;
            if (state == S_DATA && rx_ready) begin
                // Shift in from the top so the first byte ends up in bits 7:0.
                word_sr  <= {rx_data, word_sr[23:8]};
                byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                csum     <= csum ^ rx_data;
`endif
            end
            if (word_wr) begin
                imem_addr  <= {14'd0, word_idx, 2'b00};
                imem_wdata <= {rx_data, word_sr};
                word_idx   <= word_idx + 16'd1;
            end
        end
    end

    // Response queue: one pending byte, sent once the transmitter is free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data    <= 8'd0;
            tx_start   <= 1'b0;
            tx_pending <= 1'b0;
            boot_error <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (state_nx == S_ERROR) boot_error <= 1'b1;
            if (state_nx == S_DONE && state != S_DONE) begin
                tx_data    <= ACK_BYTE;
                tx_pending <= 1'b1;
            end else if (state_nx == S_ERROR && state != S_ERROR) begin
                tx_data    <= NAK_BYTE;
                tx_pending <= 1'b1;
            end else if (tx_pending && !tx_busy) begin
                tx_start   <= 1'b1;
                tx_pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_boot_loader.sv
`timescale 1ns/1ps
// Directed bench for uart_boot_loader: loads, length errors, timeout, busy transmitter and mid-load reset.
module tb_uart_boot_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready = 1'b0;
    logic        tx_busy = 1'b0;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_reset;
    logic        boot_done;
    logic        boot_error;
    logic [2:0]  fsm_state;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  csum_acc = 8'd0;

    logic [31:0] exp_q[$];
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];
    logic [7:0]  tx_q[$];

    uart_boot_loader #(.MAX_WORDS(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_reset(cpu_reset), .boot_done(boot_done), .boot_error(boot_error),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
        if (tx_start) tx_q.push_back(tx_data);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic start_load(input logic [15:0] n);
        csum_acc = 8'd0;
        send(8'hA5);
        send(n[7:0]);
        send(n[15:8]);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            csum_acc = csum_acc ^ b;
            send(b);
        end
        exp_q.push_back(w);
    endtask

    task automatic send_csum();
`ifdef BOOT_CHECKSUM_EN
        send(csum_acc);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        tx_q.delete();
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    task automatic check_writes(input string tag);
        check({tag, "_wr_count"}, 32'(wr_data_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [31:0] d, a;
            d = (i < wr_data_q.size()) ? wr_data_q[i] : 32'hxxxxxxxx;
            a = (i < wr_addr_q.size()) ? wr_addr_q[i] : 32'hxxxxxxxx;
            check({tag, "_wr_data"}, d, exp_q[i]);
            check({tag, "_wr_addr"}, a, 32'(i * 4));
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        exp_q.delete();
    endtask

    task automatic check_tx(input string tag, input int n, input logic [7:0] b);
        check({tag, "_tx_count"}, 32'(tx_q.size()), 32'(n));
        if (n > 0) check({tag, "_tx_byte"}, 32'((tx_q.size() > 0) ? tx_q[0] : 8'hxx), 32'(b));
        tx_q.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_boot_done", 32'(boot_done), 32'd0);
        check("rst_boot_error", 32'(boot_error), 32'd0);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_imem_addr", imem_addr, 32'd0);
        check("rst_imem_wdata", imem_wdata, 32'd0);
        check("rst_state", 32'(fsm_state), 32'd0);
        rst_n = 1'b1;

        // Zero-length load, then stray bytes, then an over-capacity length.
        start_load(16'd0);
        repeat (4) @(negedge clk);
        check_tx("len0", 1, 8'h15);
        check("len0_boot_error", 32'(boot_error), 32'd1);
        check("len0_cpu_reset", 32'(cpu_reset), 32'd1);
        check("len0_state", 32'(fsm_state), 32'd0);
        check_writes("len0");
        send(8'h06);
        send(8'h00);
        check("stray_state", 32'(fsm_state), 32'd0);
        start_load(16'd5);
        repeat (4) @(negedge clk);
        check_tx("len5", 1, 8'h15);
        check("len5_state", 32'(fsm_state), 32'd0);
        check("len5_boot_error", 32'(boot_error), 32'd1);

        do_reset();
        check("reset_clears_error", 32'(boot_error), 32'd0);

        // Two-word program.
        start_load(16'd2);
        send_word(32'h00000013);
        check("load_cpu_reset_mid", 32'(cpu_reset), 32'd1);
        check("load_boot_done_mid", 32'(boot_done), 32'd0);
        send_word(32'h00100093);
        send_csum();
        repeat (4) @(negedge clk);
        check_writes("load2");
        check_tx("load2", 1, 8'h06);
        check("load2_cpu_reset", 32'(cpu_reset), 32'd0);
        check("load2_boot_done", 32'(boot_done), 32'd1);
        check("load2_boot_error", 32'(boot_error), 32'd0);
        check("load2_state", 32'(fsm_state), 32'd5);
        // DONE ignores further traffic, including a new sync byte.
        send(8'hA5);
        send(8'h00);
        send(8'h00);
        repeat (4) @(negedge clk);
        check_tx("done_ignore", 0, 8'h00);
        check_writes("done_ignore");
        check("done_ignore_state", 32'(fsm_state), 32'd5);
        check("done_ignore_error", 32'(boot_error), 32'd0);

        // A byte landing on the last allowed cycle is accepted; A5 mid-payload is data.
        do_reset();
        start_load(16'd1);
        csum_acc = 8'h11;
        send(8'h11);
        repeat (TO - 1) @(negedge clk);
        csum_acc = csum_acc ^ 8'hA5 ^ 8'h33 ^ 8'h44;
        send(8'hA5);
        send(8'h33);
        send(8'h44);
        exp_q.push_back(32'h4433A511);
        send_csum();
        repeat (4) @(negedge clk);
        check_writes("edge_byte");
        check_tx("edge_byte", 1, 8'h06);
        check("edge_byte_error", 32'(boot_error), 32'd0);
        check("edge_byte_done", 32'(boot_done), 32'd1);

        // Silence mid-word triggers a timeout.
        do_reset();
        start_load(16'd1);
        send(8'h11);
        send(8'h22);
        repeat (30) @(negedge clk);
        check("to_early_error", 32'(boot_error), 32'd0);
        check("to_early_state", 32'(fsm_state), 32'd3);
        repeat (20) @(negedge clk);
        check("to_error", 32'(boot_error), 32'd1);
        check("to_cpu_reset", 32'(cpu_reset), 32'd1);
        check("to_state", 32'(fsm_state), 32'd0);
        check_tx("to", 1, 8'h15);
        check_writes("to");

        // Full-capacity load with the transmitter busy at DONE entry.
        do_reset();
        tx_busy = 1'b1;
        start_load(16'd4);
        send_word(32'hEFBEADDE);
        send_word(32'h01234567);
        send_word(32'h89ABCDEF);
        send_word(32'hCAFEF00D);
        send_csum();
        repeat (10) @(negedge clk);
        check_writes("busy");
        check_tx("busy_held", 0, 8'h00);
        check("busy_tx_data", 32'(tx_data), 32'h06);
        check("busy_done", 32'(boot_done), 32'd1);
        tx_busy = 1'b0;
        repeat (5) @(negedge clk);
        check_tx("busy_release", 1, 8'h06);

        // Reset in the middle of the payload.
        do_reset();
        start_load(16'd2);
        send_word(32'h00000013);
        send(8'h93);
        send(8'h00);
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_q.push_back(32'h00000013);
        check_writes("midrst_pre");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", 32'(imem_we), 32'd0);
        check("midrst_addr", imem_addr, 32'd0);
        check("midrst_wdata", imem_wdata, 32'd0);
        check("midrst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("midrst_state", 32'(fsm_state), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tx_q.delete();
        start_load(16'd1);
        send_word(32'h00000073);
        send_csum();
        repeat (4) @(negedge clk);
        check_writes("midrst_post");
        check_tx("midrst_post", 1, 8'h06);
        check("midrst_post_done", 32'(boot_done), 32'd1);

`ifdef BOOT_CHECKSUM_EN
        // Checksum accepted and rejected.
        do_reset();
        start_load(16'd1);
        send_word(32'h08040201);
        send(8'h0F);
        repeat (4) @(negedge clk);
        check_writes("csum_ok");
        check_tx("csum_ok", 1, 8'h06);
        check("csum_ok_done", 32'(boot_done), 32'd1);
        do_reset();
        start_load(16'd1);
        send_word(32'h08040201);
        send(8'h0E);
        repeat (4) @(negedge clk);
        check_writes("csum_bad");
        check_tx("csum_bad", 1, 8'h15);
        check("csum_bad_error", 32'(boot_error), 32'd1);
        check("csum_bad_cpu_reset", 32'(cpu_reset), 32'd1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_boot_loader.md
UART_BOOT_LOADER -- requirements
Module: uart_boot_loader

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning instruction-memory capacity in 32-bit words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000, meaning maximum clk cycles allowed between bytes in a transfer.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 SHALL have port rx_data, input, 8, the received UART byte.
REQ-006 SHALL have port rx_ready, input, 1, a one-cycle pulse marking rx_data valid.
REQ-007 SHALL have port tx_data, output, 8, the response byte to the UART.
REQ-008 SHALL have port tx_start, output, 1, a one-cycle transmit request.
REQ-009 SHALL have port tx_busy, input, 1, asserted while the UART transmitter is occupied.
REQ-010 SHALL have port imem_we, output, 1, the instruction-memory write strobe.
REQ-011 SHALL have port imem_addr, output, 32, the instruction-memory byte address.
REQ-012 SHALL have port imem_wdata, output, 32, the instruction word to write.
REQ-013 SHALL have port cpu_reset, output, 1, the active-high core reset; it holds the processor in reset while loading.
REQ-014 SHALL have port boot_done, output, 1, the load-complete flag.
REQ-015 SHALL have port boot_error, output, 1, a sticky flag set on any failed load since reset.

Function
REQ-016 SHALL implement states IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE and ERROR.
REQ-017 IDLE SHALL ignore every byte except sync byte 0xA5, which moves the FSM to LEN_LO.
REQ-018 LEN_LO and LEN_HI SHALL capture word count N as a little-endian 16-bit value, then move to DATA.
REQ-019 If N==0 or N>MAX_WORDS when LEN_HI completes, the FSM SHALL go to ERROR.
REQ-020 DATA SHALL assemble each group of 4 bytes little-endian (first byte is bits 7:0) into one word.
REQ-021 imem_we SHALL pulse for exactly one cycle, in the cycle after the 4th byte's rx_ready.
- During that pulse, imem_addr = word_index*4 and imem_wdata = the assembled word.
- word_index counts from 0 to N-1.
REQ-022 After word N-1 is written, the FSM SHALL go to CSUM if BOOT_CHECKSUM_EN is defined, otherwise to DONE.
REQ-023 An inter-byte counter SHALL run in LEN_LO, LEN_HI, DATA and CSUM, clearing on each rx_ready.
- When it reaches TIMEOUT_CYCLES, the FSM SHALL go to ERROR.
REQ-024 On entry to DONE, the block SHALL:
- deassert cpu_reset in the entry cycle;
- set boot_done;
- queue ACK byte 0x06.
REQ-025 DONE SHALL be terminal until reset, and SHALL ignore all rx bytes.
REQ-026 ERROR SHALL:
- set boot_error;
- queue NAK byte 0x15;
- keep cpu_reset high;
- return to IDLE the next cycle.
REQ-027 A queued response SHALL issue tx_start for one cycle only when tx_busy is low; otherwise it SHALL wait with tx_data held.
REQ-028 If rx_ready and a timeout occur in the same cycle, the byte SHALL win and the counter SHALL clear.
REQ-029 A second 0xA5 arriving mid-transfer SHALL be treated as data, not as a restart.

Reset
REQ-030 While rst_n is low, the block SHALL be asynchronously forced to:
- FSM state IDLE;
- cpu_reset=1;
- imem_we=0, tx_start=0, boot_done=0, boot_error=0;
- imem_addr=0, imem_wdata=0, tx_data=0;
- all counters and the checksum cleared.
REQ-031 A reset asserted mid-transfer SHALL abort the transfer, leaving already-written words in memory.

Configuration
REQ-032 With macro BOOT_CHECKSUM_EN defined, the block SHALL keep an 8-bit XOR of all payload bytes.
- CSUM state receives one byte.
- Match -> DONE; mismatch -> ERROR.
REQ-033 Without BOOT_CHECKSUM_EN, no checksum logic or CSUM transitions SHALL exist, and the last data word SHALL go directly to DONE.

Verification
REQ-034 Bytes A5 02 00 13 00 00 00 93 00 10 00 -> two write pulses:
- addr 0x0 = 0x00000013;
- addr 0x4 = 0x00100093;
- then tx_data 0x06, cpu_reset 0, boot_done 1 (checksum-disabled build).
REQ-035 Bytes A5 00 00 -> ERROR: NAK 0x15 sent, boot_error 1, cpu_reset 1, FSM back in IDLE.
REQ-036 Bytes A5 01 00 11 22, then silence for TIMEOUT_CYCLES -> ERROR with no imem_we pulse.
REQ-037 Checksum build, bytes A5 01 00 01 02 04 08 0F -> write 0x08040201, then ACK; trailing byte 0E instead -> NAK.
REQ-038 tx_busy held high at DONE entry -> no tx_start until tx_busy falls, then exactly one pulse carrying 0x06.
REQ-039 rst_n pulsed low after 6 DATA bytes -> all outputs return to their reset values; a fresh A5 load then succeeds.
